// File: rtl/aes128_encrypt.sv
// Iterative AES-128 encryption core: one round per clock, valid/ready input handshake,
// one-cycle out_valid pulse with the ciphertext held until the next completion.
module aes128_encrypt (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         ready,
    input  logic [127:0] input_message,
    input  logic [127:0] cipher_key,
    output logic [127:0] coded_message,
    output logic         out_valid
);

    typedef enum logic {StIdle, StRun} ctrl_t;

    // FIPS-197 S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] rc;
        case (r)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w0 = k[127:96] ^ sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h0};
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Byte k (k=0 is the MSB byte) sits at row k%4, column k/4.
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[8*(15-(r+4*c)) +: 8] = sbox(s[8*(15-(r+4*((c+r)%4))) +: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] a);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = a;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    ctrl_t        ctrl_q, ctrl_d;
    logic [127:0] blk_q, blk_d;
    logic [127:0] rkey_q, rkey_d;
    logic [3:0]   round_q, round_d;
    logic [127:0] coded_d;
    logic         out_valid_d;
    logic [127:0] next_rkey, shifted, mixed, round_res;

    // One AES round plus one key-schedule step, and the control next-state.
    always_comb begin
        next_rkey   = key_step(rkey_q, rcon(round_q));
        shifted     = sub_shift(blk_q);
        mixed       = {mix_col(shifted[127:96]), mix_col(shifted[95:64]),
                       mix_col(shifted[63:32]), mix_col(shifted[31:0])};
        round_res   = ((round_q == 4'd10) ? shifted : mixed) ^ next_rkey;
        ctrl_d      = ctrl_q;
        blk_d       = blk_q;
        rkey_d      = rkey_q;
        round_d     = round_q;
        coded_d     = coded_message;
        out_valid_d = 1'b0;
        ready       = (ctrl_q == StIdle);
        unique case (ctrl_q)
            StIdle: begin
                if (in_valid) begin
                    blk_d   = input_message ^ cipher_key;
                    rkey_d  = cipher_key;
                    round_d = 4'd1;
                    ctrl_d  = StRun;
                end
            end
            StRun: begin
                blk_d   = round_res;
                rkey_d  = next_rkey;
                round_d = round_q + 4'd1;
                if (round_q == 4'd10) begin
                    coded_d     = round_res;
                    out_valid_d = 1'b1;
                    ctrl_d      = StIdle;
                end
            end
            default: ctrl_d = StIdle;
        endcase
    end

    // State registers; reset aborts any block in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q        <= StIdle;
            blk_q         <= '0;
            rkey_q        <= '0;
            round_q       <= '0;
            coded_message <= '0;
            out_valid     <= 1'b0;
        end else begin
            ctrl_q        <= ctrl_d;
            blk_q         <= blk_d;
            rkey_q        <= rkey_d;
            round_q       <= round_d;
            coded_message <= coded_d;
            out_valid     <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_aes128_encrypt.sv
// Directed-vector bench for aes128_encrypt: known-answer table plus busy, back-to-back
// and mid-operation reset sequences.
module tb_aes128_encrypt;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         ready;
    logic [127:0] input_message;
    logic [127:0] cipher_key;
    logic [127:0] coded_message;
    logic         out_valid;

    int checks = 0;
    int failures = 0;

    aes128_encrypt dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .ready         (ready),
        .input_message (input_message),
        .cipher_key    (cipher_key),
        .coded_message (coded_message),
        .out_valid     (out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Counts edges from the acceptance edge (=1) until out_valid is seen, bounded.
    task automatic wait_done(output int cnt, output int ready_high);
        cnt = 1;
        ready_high = 0;
        while (!out_valid && cnt < 40) begin
            if (ready) ready_high++;
            @(posedge clk);
            #1;
            cnt++;
        end
    endtask

    // Offers one block, waits for the result and checks latency, busy and pulse width.
    task automatic run_block(input string name, input vec_t v);
        int cnt, rh;
        @(negedge clk);
        check({name, " ready_idle"}, 128'(ready), 128'd1);
        in_valid      = 1'b1;
        cipher_key    = v.key;
        input_message = v.pt;
        @(posedge clk);
        #1;
        in_valid      = 1'b0;
        input_message = ~v.pt;
        cipher_key    = ~v.key;
        wait_done(cnt, rh);
        check({name, " latency"}, 128'(cnt), 128'd11);
        check({name, " ready_low_busy"}, 128'(rh), 128'd0);
        check({name, " out_valid"}, 128'(out_valid), 128'd1);
        check({name, " ct"}, coded_message, v.ct);
        @(posedge clk);
        #1;
        check({name, " pulse_one_cycle"}, 128'(out_valid), 128'd0);
        check({name, " ct_hold"}, coded_message, v.ct);
    endtask

    initial begin
        int cnt, rh, seen;
        vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
                    128'h3925841d02dc09fbdc118597196a0b32};
        vecs[2] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
        vecs[3] = '{128'h5468617473206d79204b756e67204675, 128'h54776f204f6e65204e696e652054776f,
                    128'h29c3505f571420f6402299b31a02d73a};

        rst = 1'b1;
        in_valid = 1'b0;
        input_message = '0;
        cipher_key = '0;
        #12;
        check("reset ready", 128'(ready), 128'd1);
        check("reset out_valid", 128'(out_valid), 128'd0);
        check("reset coded", coded_message, 128'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            run_block($sformatf("vec%0d", i), vecs[i]);
        end

        // Busy: in_valid held high with changing data; then back-to-back App. B.
        @(negedge clk);
        in_valid      = 1'b1;
        cipher_key    = vecs[0].key;
        input_message = vecs[0].pt;
        @(posedge clk);
        #1;
        cnt = 1;
        rh  = 0;
        while (!out_valid && cnt < 40) begin
            if (ready) rh++;
            input_message = {$urandom, $urandom, $urandom, $urandom};
            cipher_key    = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk);
            #1;
            cnt++;
        end
        check("busy latency", 128'(cnt), 128'd11);
        check("busy ready_low", 128'(rh), 128'd0);
        check("busy ct", coded_message, vecs[0].ct);
        check("b2b ready_with_out_valid", 128'(ready), 128'd1);
        cipher_key    = vecs[1].key;
        input_message = vecs[1].pt;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("b2b accepted", 128'(ready), 128'd0);
        check("b2b out_valid_drop", 128'(out_valid), 128'd0);
        wait_done(cnt, rh);
        check("b2b latency", 128'(cnt), 128'd11);
        check("b2b ct", coded_message, vecs[1].ct);

        // Reset in round 5: outputs clear at once and no pulse follows.
        @(negedge clk);
        in_valid      = 1'b1;
        cipher_key    = vecs[3].key;
        input_message = vecs[3].pt;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        check("midrst before coded", coded_message, vecs[1].ct);
        rst = 1'b1;
        #1;
        check("midrst coded", coded_message, 128'd0);
        check("midrst ready", 128'(ready), 128'd1);
        check("midrst out_valid", 128'(out_valid), 128'd0);
        #1;
        rst = 1'b0;
        seen = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("midrst no_pulse", 128'(seen), 128'd0);
        check("midrst coded_stays", coded_message, 128'd0);
        run_block("after_rst", vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
